display_scan_controller: RTL and testbench

- Sequences time-multiplexed scanning of the stopwatch's seven-segment digits.
- Generates per-digit drive slots with an anti-ghosting blank interval, and snapshots the displayed number at frame boundaries so no frame shows a torn value.
- Applies leading-zero suppression and per-digit blinking.
- Feeds the existing BCD_n segment decoder: digit goes to BCD_n, digit_blank gates its output.

---
 rtl/display_pkg.sv | 18 +
 rtl/display_tick_divider.sv | 29 ++
 rtl/display_scan_controller.sv | 157 +++++++++++++++
 tb/tb_display_scan_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and default timing for the stopwatch seven-segment scan logic.
// Defaults assume a 125 MHz system clock.
package display_pkg;

    localparam int BCD_WIDTH = 4;

    localparam int DEFAULT_NUMBER_OF_DIGITS  = 4;
    localparam int DEFAULT_SLOT_CYCLES       = 125_000;     // 1 ms per digit slot
    localparam int DEFAULT_BLANK_CYCLES      = 1_000;       // 8 us anti-ghosting gap
    localparam int DEFAULT_BLINK_HALF_CYCLES = 62_500_000;  // 0.5 s per blink phase

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_DRIVE
    } scan_state_e;

endpackage

// File: rtl/display_tick_divider.sv
// Free-running modulo-DIVISOR counter emitting a one-cycle tick on every
// DIVISOR-th enabled cycle.
module display_tick_divider #(
    parameter int DIVISOR = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    logic [CNT_W-1:0] r_count;
    logic             w_terminal;

    assign w_terminal = (r_count == CNT_W'(DIVISOR - 1));
    assign tick       = enable && w_terminal;

    // NOTE: state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_terminal ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed digit scanner: blank/drive slots per digit, frame-aligned
// snapshot of the number, leading-zero suppression and per-digit blinking.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int NUMBER_OF_DIGITS  = DEFAULT_NUMBER_OF_DIGITS,
    parameter int SLOT_CYCLES       = DEFAULT_SLOT_CYCLES,
    parameter int BLANK_CYCLES      = DEFAULT_BLANK_CYCLES,
    parameter int BLINK_HALF_CYCLES = DEFAULT_BLINK_HALF_CYCLES
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  enable,
    input  logic [BCD_WIDTH*NUMBER_OF_DIGITS-1:0] number,
    input  logic                                  number_valid,
    input  logic [NUMBER_OF_DIGITS-1:0]           blink_mask,
    input  logic                                  suppress_zeros,
    output logic [NUMBER_OF_DIGITS-1:0]           io_sel,
    output logic [BCD_WIDTH-1:0]                  digit,
    output logic                                  digit_blank,
    output logic                                  frame_done
);

    localparam int NUM_W       = BCD_WIDTH * NUMBER_OF_DIGITS;
    localparam int IDX_W       = (NUMBER_OF_DIGITS > 1) ? $clog2(NUMBER_OF_DIGITS) : 1;
    localparam int SLOT_W      = $clog2(SLOT_CYCLES);
    localparam int DRIVE_CYCLES = SLOT_CYCLES - BLANK_CYCLES;

    localparam logic [IDX_W-1:0]  LAST_INDEX    = IDX_W'(NUMBER_OF_DIGITS - 1);
    localparam logic [SLOT_W-1:0] BLANK_TERMINAL = SLOT_W'(BLANK_CYCLES - 1);
    localparam logic [SLOT_W-1:0] DRIVE_TERMINAL = SLOT_W'(DRIVE_CYCLES - 1);

    scan_state_e           r_state;
    logic [IDX_W-1:0]      r_index;
    logic [SLOT_W-1:0]     r_slot_timer;
    logic [NUM_W-1:0]      r_capture;
    logic [NUM_W-1:0]      r_display;
    logic                  r_blink_phase;
    logic [NUMBER_OF_DIGITS-1:0] r_io_sel;
    logic [BCD_WIDTH-1:0]  r_digit;
    logic                  r_digit_blank;
    logic                  r_frame_done;

    logic                  w_blink_tick;
    logic                  w_phase_next;
    logic [NUM_W-1:0]      w_frame_number;
    logic [IDX_W-1:0]      w_index_next;
    logic [NUMBER_OF_DIGITS-1:0] w_sel_drive;
    logic                  w_upper_zero;
    logic                  w_suppress;
    logic                  w_drive_blank;

    display_tick_divider #(
        .DIVISOR (BLINK_HALF_CYCLES)
    ) u_blink_divider (
        .clk    (clk),
        .rst    (rst),
        .enable (1'b1),
        .tick   (w_blink_tick)
    );

    // A number presented on the frame-start edge wins over the stale capture.
    assign w_frame_number = number_valid ? number : r_capture;
    assign w_phase_next   = r_blink_phase ^ w_blink_tick;
    assign w_index_next   = r_index + 1'b1;
    assign w_sel_drive    = ~(NUMBER_OF_DIGITS'(1) << r_index);

    // NOTE: give every always_comb output a default first so no latch is inferred.
    always_comb begin
        w_upper_zero = 1'b1;
        for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
            if (i >= int'(r_index) && r_display[BCD_WIDTH*i +: BCD_WIDTH] != '0)
                w_upper_zero = 1'b0;
        end
    end

    assign w_suppress    = suppress_zeros && (r_index != '0) && w_upper_zero;
    assign w_drive_blank = w_suppress || (blink_mask[r_index] && w_phase_next);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_index       <= '0;
            r_slot_timer  <= '0;
            r_capture     <= '0;
            r_display     <= '0;
            r_blink_phase <= 1'b0;
            r_io_sel      <= '1;
            r_digit       <= '0;
            r_digit_blank <= 1'b1;
            r_frame_done  <= 1'b0;
        end else begin
            r_blink_phase <= w_phase_next;
            r_frame_done  <= 1'b0;
            if (number_valid)
                r_capture <= number;

            if (r_state != ST_IDLE && !enable) begin
                r_state       <= ST_IDLE;
                r_index       <= '0;
                r_slot_timer  <= '0;
                r_io_sel      <= '1;
                r_digit       <= r_display[BCD_WIDTH-1:0];
                r_digit_blank <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (enable) begin
                            r_state      <= ST_BLANK;
                            r_index      <= '0;
                            r_slot_timer <= '0;
                            r_display    <= w_frame_number;
                            r_digit      <= w_frame_number[BCD_WIDTH-1:0];
                        end
                    end
                    ST_BLANK: begin
                        if (r_slot_timer == BLANK_TERMINAL) begin
                            r_state       <= ST_DRIVE;
                            r_slot_timer  <= '0;
                            r_io_sel      <= w_sel_drive;
                            r_digit_blank <= w_drive_blank;
                        end else begin
                            r_slot_timer <= r_slot_timer + 1'b1;
                        end
                    end
                    ST_DRIVE: begin
                        if (r_slot_timer == DRIVE_TERMINAL) begin
                            r_state       <= ST_BLANK;
                            r_slot_timer  <= '0;
                            r_io_sel      <= '1;
                            r_digit_blank <= 1'b1;
                            if (r_index == LAST_INDEX) begin
                                r_index      <= '0;
                                r_frame_done <= 1'b1;
                                r_display    <= w_frame_number;
                                r_digit      <= w_frame_number[BCD_WIDTH-1:0];
                            end else begin
                                r_index <= w_index_next;
                                r_digit <= r_display[BCD_WIDTH*w_index_next +: BCD_WIDTH];
                            end
                        end else begin
                            r_slot_timer  <= r_slot_timer + 1'b1;
                            r_digit_blank <= w_drive_blank;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign io_sel      = r_io_sel;
    assign digit       = r_digit;
    assign digit_blank = r_digit_blank;
    assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with a 10-cycle slot (2 blank),
// 4 digits and a 40-cycle blink half period.
module tb_display_scan_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] number;
    logic        number_valid;
    logic [3:0]  blink_mask;
    logic        suppress_zeros;
    logic [3:0]  io_sel;
    logic [3:0]  digit;
    logic        digit_blank;
    logic        frame_done;

    int tests_run    = 0;
    int tests_failed = 0;
    int k            = 0;   // edges since reset, i.e. the blink timer's age

    logic [9:0] obs   [40];
    int         obs_k [40];

    display_scan_controller #(
        .NUMBER_OF_DIGITS  (4),
        .SLOT_CYCLES       (10),
        .BLANK_CYCLES      (2),
        .BLINK_HALF_CYCLES (40)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .number         (number),
        .number_valid   (number_valid),
        .blink_mask     (blink_mask),
        .suppress_zeros (suppress_zeros),
        .io_sel         (io_sel),
        .digit          (digit),
        .digit_blank    (digit_blank),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    // Expected {io_sel, digit, digit_blank, frame_done} at cycle c of a frame.
    function automatic logic [9:0] exp_vec(input int c, input logic [15:0] num,
                                           input logic [3:0] drive_blank, input logic done0);
        int         s  = c / 10;
        int         t  = c % 10;
        logic [3:0] sel = (t < 2) ? 4'hF : ~(4'b0001 << s);
        logic [3:0] dg  = num[4*s +: 4];
        logic       bl  = (t < 2) ? 1'b1 : drive_blank[s];
        logic       dn  = (c == 0) ? done0 : 1'b0;
        return {sel, dg, bl, dn};
    endfunction

    // Records one 40-cycle frame starting at the current negedge; optionally
    // presents new_num with number_valid for one cycle after sample valid_at.
    task automatic capture_frame(input int valid_at, input logic [15:0] new_num);
        for (int c = 0; c < 40; c++) begin
            obs[c]   = {io_sel, digit, digit_blank, frame_done};
            obs_k[c] = k;
            if (c == valid_at) begin
                number       = new_num;
                number_valid = 1'b1;
            end else begin
                number_valid = 1'b0;
            end
            @(negedge clk);
        end
        number_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; number = '0; number_valid = 1'b0;
        blink_mask = '0; suppress_zeros = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run += 4;
        if (io_sel !== 4'hF) begin tests_failed++; $display("FAIL reset_io_sel got %h expected f", io_sel); end
        if (digit !== 4'h0) begin tests_failed++; $display("FAIL reset_digit got %h expected 0", digit); end
        if (digit_blank !== 1'b1) begin tests_failed++; $display("FAIL reset_blank got %b expected 1", digit_blank); end
        if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b expected 0", frame_done); end
    endtask

    task automatic test_scan_order();
        logic [9:0] e;
        rst = 1'b0; enable = 1'b1; number = 16'h1234; number_valid = 1'b1;
        @(negedge clk);
        number_valid = 1'b0;
        for (int f = 0; f < 2; f++) begin
            capture_frame(-1, 16'h0000);
            for (int c = 0; c < 40; c++) begin
                e = exp_vec(c, 16'h1234, 4'b0000, f != 0);
                tests_run++;
                if (obs[c] !== e) begin
                    tests_failed++;
                    $display("FAIL scan_order frame=%0d c=%0d got %h expected %h", f, c, obs[c], e);
                end
            end
        end
    endtask

    task automatic test_tearing();
        logic [9:0] e;
        capture_frame(15, 16'h5678);
        for (int c = 0; c < 40; c++) begin
            e = exp_vec(c, 16'h1234, 4'b0000, 1'b1);
            tests_run++;
            if (obs[c] !== e) begin
                tests_failed++;
                $display("FAIL tearing_old c=%0d got %h expected %h", c, obs[c], e);
            end
        end
        capture_frame(39, 16'h0040);
        for (int c = 0; c < 40; c++) begin
            e = exp_vec(c, 16'h5678, 4'b0000, 1'b1);
            tests_run++;
            if (obs[c] !== e) begin
                tests_failed++;
                $display("FAIL tearing_new c=%0d got %h expected %h", c, obs[c], e);
            end
        end
    endtask

    task automatic test_zero_suppress();
        logic [9:0] e;
        suppress_zeros = 1'b1;
        capture_frame(39, 16'h0000);
        for (int c = 0; c < 40; c++) begin
            e = exp_vec(c, 16'h0040, 4'b1100, 1'b1);
            tests_run++;
            if (obs[c] !== e) begin
                tests_failed++;
                $display("FAIL suppress_0040 c=%0d got %h expected %h", c, obs[c], e);
            end
        end
        capture_frame(39, 16'h1234);
        for (int c = 0; c < 40; c++) begin
            e = exp_vec(c, 16'h0000, 4'b1110, 1'b1);
            tests_run++;
            if (obs[c] !== e) begin
                tests_failed++;
                $display("FAIL suppress_0000 c=%0d got %h expected %h", c, obs[c], e);
            end
        end
        suppress_zeros = 1'b0;
    endtask

    task automatic test_blink();
        logic [9:0] e;
        logic       phase;
        int         on_cycles = 0;
        blink_mask = 4'b0010;
        for (int f = 0; f < 2; f++) begin
            capture_frame(-1, 16'h0000);
            for (int c = 0; c < 40; c++) begin
                phase = ((obs_k[c] / 40) % 2) == 1;
                if (phase && c >= 12 && c < 20) on_cycles++;
                e = exp_vec(c, 16'h1234, {2'b00, phase, 1'b0}, 1'b1);
                tests_run++;
                if (obs[c] !== e) begin
                    tests_failed++;
                    $display("FAIL blink frame=%0d c=%0d got %h expected %h", f, c, obs[c], e);
                end
            end
        end
        tests_run++;
        if (on_cycles == 0) begin
            tests_failed++;
            $display("FAIL blink_window got %0d blanked cycles expected >0", on_cycles);
        end
        blink_mask = '0;
    endtask

    task automatic test_enable_drop();
        logic [9:0] e;
        repeat (25) @(negedge clk);
        tests_run++;
        if (io_sel !== 4'b1011) begin tests_failed++; $display("FAIL drop_pre_sel got %b expected 1011", io_sel); end
        enable = 1'b0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            tests_run++;
            if ({io_sel, digit_blank, frame_done} !== 6'b1111_1_0) begin
                tests_failed++;
                $display("FAIL drop_dark c=%0d got %b expected 111110", c, {io_sel, digit_blank, frame_done});
            end
        end
        enable = 1'b1;
        @(negedge clk);
        capture_frame(-1, 16'h0000);
        for (int c = 0; c < 40; c++) begin
            e = exp_vec(c, 16'h1234, 4'b0000, 1'b0);
            tests_run++;
            if (obs[c] !== e) begin
                tests_failed++;
                $display("FAIL drop_restart c=%0d got %h expected %h", c, obs[c], e);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] e;
        repeat (5) @(negedge clk);
        tests_run++;
        if (io_sel !== 4'b1110) begin tests_failed++; $display("FAIL rstmid_pre_sel got %b expected 1110", io_sel); end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({io_sel, digit, digit_blank, frame_done} !== 10'b1111_0000_1_0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs got %b expected 1111000010", {io_sel, digit, digit_blank, frame_done});
        end
        rst = 1'b0;
        @(negedge clk);
        capture_frame(-1, 16'h0000);
        for (int c = 0; c < 40; c++) begin
            e = exp_vec(c, 16'h0000, 4'b0000, 1'b0);
            tests_run++;
            if (obs[c] !== e) begin
                tests_failed++;
                $display("FAIL rstmid_cleared c=%0d got %h expected %h", c, obs[c], e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_tearing();
        test_zero_suppress();
        test_blink();
        test_enable_drop();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
